// File: rtl/nco_pkg.sv
// nco_pkg: shared defaults and lane-packing helpers for the nco_bank accumulator bank.
// Rev 1.0
`default_nettype none

package nco_pkg;

    localparam int              DEF_W       = 32;
    localparam longint unsigned DEF_MODULUS = 64'd100000000;
    localparam int              CNT_W       = 16;

    typedef enum logic [1:0] {
        ACT_HOLD    = 2'd0,
        ACT_LOAD    = 2'd1,
        ACT_ADVANCE = 2'd2,
        ACT_REJECT  = 2'd3
    } lane_act_e;

    // Lowest bit index of a lane inside a packed NCH*width bus.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/nco_lane.sv
// nco_lane: one modulo phase accumulator lane with load, advance and freq-range check.
// Rev 1.0 -- optional wrap counter enabled by NCO_OVF_CNT_EN.
`default_nettype none

module nco_lane
    import nco_pkg::*;
#(
    parameter int              W       = DEF_W,
    parameter longint unsigned MODULUS = DEF_MODULUS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sync,
    input  logic         push_s,
    input  logic [W-1:0] phase,
    input  logic [W-1:0] freq,
    output logic         sync1,
    output logic         ovf,
    output logic [W-1:0] acc,
    output logic         freq_err
`ifdef NCO_OVF_CNT_EN
    ,
    output logic [CNT_W-1:0] ovf_cnt
`endif
);

    localparam logic [W-1:0] MOD_W  = W'(MODULUS);
    localparam logic [W:0]   MOD_W1 = (W+1)'(MODULUS);

    lane_act_e    action;
    logic [W:0]   sum;
    logic [W-1:0] acc_wrap;
    logic [W-1:0] load_val;
    logic         freq_bad;
    logic         wrap;

    // Sum is kept one bit wider so the compare sees the true value.
    assign sum      = {1'b0, acc} + {1'b0, freq};
    assign wrap     = (sum >= MOD_W1);
    assign acc_wrap = acc + freq - MOD_W;
    assign freq_bad = (freq >= MOD_W);
    assign load_val = (phase < MOD_W) ? phase : (phase - MOD_W);

    always_comb begin
        action = ACT_HOLD;
        if (sync) begin
            action = ACT_LOAD;
        end else if (push_s) begin
            action = freq_bad ? ACT_REJECT : ACT_ADVANCE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc      <= '0;
            ovf      <= 1'b0;
            sync1    <= 1'b0;
            freq_err <= 1'b0;
        end else begin
            sync1 <= sync;
            ovf   <= 1'b0;
            unique case (action)
                ACT_HOLD: begin
                end
                ACT_LOAD: begin
                    acc      <= load_val;
                    freq_err <= 1'b0;
                end
                ACT_ADVANCE: begin
                    acc <= wrap ? acc_wrap : sum[W-1:0];
                    ovf <= wrap;
                end
                ACT_REJECT: begin
                    freq_err <= 1'b1;
                end
            endcase
        end
    end

`ifdef NCO_OVF_CNT_EN
    // Counts on the same edge that raises ovf, so it tracks ovf pulses one-for-one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_cnt <= '0;
        end else if (sync) begin
            ovf_cnt <= '0;
        end else if ((action == ACT_ADVANCE) && wrap) begin
            ovf_cnt <= ovf_cnt + 1'b1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/nco_bank.sv
// nco_bank: NCH independent modulo phase accumulators (numerically controlled oscillators).
// Rev 1.0 -- define NCO_OVF_CNT_EN to add the per-lane ovf_cnt wrap counters.
`default_nettype none

module nco_bank
    import nco_pkg::*;
#(
    parameter int              NCH     = 4,
    parameter int              W       = DEF_W,
    parameter longint unsigned MODULUS = DEF_MODULUS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   sync,
    input  logic [NCH-1:0]   push_s,
    input  logic [NCH*W-1:0] phase,
    input  logic [NCH*W-1:0] freq,
    output logic [NCH-1:0]   sync1,
    output logic [NCH-1:0]   ovf,
    output logic [NCH*W-1:0] acc,
    output logic [NCH-1:0]   freq_err
`ifdef NCO_OVF_CNT_EN
    ,
    output logic [NCH*CNT_W-1:0] ovf_cnt
`endif
);

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        nco_lane #(
            .W       (W),
            .MODULUS (MODULUS)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .sync     (sync[i]),
            .push_s   (push_s[i]),
            .phase    (phase[lane_lo(i, W) +: W]),
            .freq     (freq[lane_lo(i, W) +: W]),
            .sync1    (sync1[i]),
            .ovf      (ovf[i]),
            .acc      (acc[lane_lo(i, W) +: W]),
            .freq_err (freq_err[i])
`ifdef NCO_OVF_CNT_EN
            ,
            .ovf_cnt  (ovf_cnt[lane_lo(i, CNT_W) +: CNT_W])
`endif
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_nco_bank.sv
// tb_nco_bank: directed and random scoreboard bench for nco_bank.
// Rev 1.0 -- define NCO_OVF_CNT_EN to include the wrap counter sequence.
`default_nettype none

module tb_nco_bank;
    import nco_pkg::*;

    localparam int              NCH = 4;
    localparam int              W   = 32;
    localparam longint unsigned M   = 64'd100000000;

    logic             clk;
    logic             reset;
    logic [NCH-1:0]   sync;
    logic [NCH-1:0]   push_s;
    logic [NCH*W-1:0] phase;
    logic [NCH*W-1:0] freq;
    logic [NCH-1:0]   sync1;
    logic [NCH-1:0]   ovf;
    logic [NCH*W-1:0] acc;
    logic [NCH-1:0]   freq_err;
`ifdef NCO_OVF_CNT_EN
    logic [NCH*16-1:0] ovf_cnt;
`endif

    nco_bank #(.NCH(NCH), .W(W), .MODULUS(M)) dut (
        .clk      (clk),
        .reset    (reset),
        .sync     (sync),
        .push_s   (push_s),
        .phase    (phase),
        .freq     (freq),
        .sync1    (sync1),
        .ovf      (ovf),
        .acc      (acc),
        .freq_err (freq_err)
`ifdef NCO_OVF_CNT_EN
        ,
        .ovf_cnt  (ovf_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            tag;
        logic [NCH*W-1:0] acc;
        logic [NCH-1:0]   ovf;
        logic [NCH-1:0]   sync1;
        logic [NCH-1:0]   ferr;
        logic [NCH*16-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    longint unsigned m_acc[NCH];
    logic [NCH-1:0]  m_ovf, m_sync1, m_ferr;
    logic [15:0]     m_cnt[NCH];

    task automatic chk_w(input string tag, input logic [NCH*W-1:0] obs, input logic [NCH*W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_n(input string tag, input logic [NCH-1:0] obs, input logic [NCH-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_acc[i] = 0;
            m_cnt[i] = 16'd0;
        end
        m_ovf   = '0;
        m_sync1 = '0;
        m_ferr  = '0;
    endtask

    // Reference behaviour of one clock edge using the inputs currently driven.
    task automatic model_step();
        longint unsigned ph, fr, s;
        for (int i = 0; i < NCH; i++) begin
            ph = 64'(phase[i*W +: W]);
            fr = 64'(freq[i*W +: W]);
            m_sync1[i] = sync[i];
            m_ovf[i]   = 1'b0;
            if (sync[i]) begin
                m_acc[i]  = (ph < M) ? ph : ph - M;
                m_ferr[i] = 1'b0;
                m_cnt[i]  = 16'd0;
            end else if (push_s[i]) begin
                if (fr >= M) begin
                    m_ferr[i] = 1'b1;
                end else begin
                    s = m_acc[i] + fr;
                    if (s >= M) begin
                        m_acc[i] = s - M;
                        m_ovf[i] = 1'b1;
                        m_cnt[i] = m_cnt[i] + 16'd1;
                    end else begin
                        m_acc[i] = s;
                    end
                end
            end
        end
    endtask

    task automatic step(input string tag);
        exp_t e;
        model_step();
        e.tag   = tag;
        e.ovf   = m_ovf;
        e.sync1 = m_sync1;
        e.ferr  = m_ferr;
        for (int i = 0; i < NCH; i++) begin
            e.acc[i*W +: W]   = W'(m_acc[i]);
            e.cnt[i*16 +: 16] = m_cnt[i];
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk_w({e.tag, "/acc"}, acc, e.acc);
        chk_n({e.tag, "/ovf"}, ovf, e.ovf);
        chk_n({e.tag, "/sync1"}, sync1, e.sync1);
        chk_n({e.tag, "/freq_err"}, freq_err, e.ferr);
`ifdef NCO_OVF_CNT_EN
        total++;
        assert (ovf_cnt === e.cnt) else begin
            bad++;
            $error("FAIL %s/ovf_cnt observed=%0h expected=%0h", e.tag, ovf_cnt, e.cnt);
        end
`endif
    endtask

    task automatic set_lane(input int i, input logic s, input logic p,
                            input logic [W-1:0] ph, input logic [W-1:0] fr);
        sync[i]          = s;
        push_s[i]        = p;
        phase[i*W +: W]  = ph;
        freq[i*W +: W]   = fr;
    endtask

    task automatic chk_all_zero(input string tag);
        chk_w({tag, "/acc"}, acc, '0);
        chk_n({tag, "/ovf"}, ovf, '0);
        chk_n({tag, "/sync1"}, sync1, '0);
        chk_n({tag, "/freq_err"}, freq_err, '0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b1;
        sync   = '0;
        push_s = '0;
        phase  = '0;
        freq   = '0;
        model_reset();
        @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;

        // Loads, including a phase at or above the modulus.
        set_lane(0, 1'b1, 1'b0, 32'd5, 32'd0);
        set_lane(1, 1'b1, 1'b0, 32'd100000005, 32'd0);
        set_lane(2, 1'b1, 1'b0, 32'd99999990, 32'd0);
        set_lane(3, 1'b1, 1'b0, 32'd0, 32'd0);
        step("load");
        chk32("load_acc0", acc[0 +: W], 32'd5);
        chk_n("load_sync1", sync1, 4'b1111);
        chk32("load_acc1_reduced", acc[W +: W], 32'd5);

        sync = '0;
        set_lane(0, 1'b0, 1'b1, 32'd0, 32'd3);
        set_lane(2, 1'b0, 1'b1, 32'd0, 32'd20);
        step("wrap");
        chk32("wrap_acc2", acc[2*W +: W], 32'd10);
        chk_n("wrap_ovf", ovf, 4'b0100);

        push_s = '0;
        step("after_wrap");
        chk_n("ovf_one_cycle", ovf, 4'b0000);

        set_lane(1, 1'b1, 1'b1, 32'd7, 32'd3);
        step("sync_push");
        chk32("sync_push_acc1", acc[W +: W], 32'd7);

        set_lane(1, 1'b0, 1'b0, 32'd0, 32'd0);
        set_lane(3, 1'b0, 1'b1, 32'd0, 32'd100000000);
        step("bad_freq");
        chk32("bad_freq_acc3", acc[3*W +: W], 32'd0);
        chk_n("bad_freq_err", freq_err, 4'b1000);
        set_lane(3, 1'b0, 1'b0, 32'd0, 32'd0);
        step("err_hold");
        set_lane(3, 1'b0, 1'b1, 32'd0, 32'd5);
        step("err_sticky");
        chk_n("err_sticky", freq_err, 4'b1000);
        set_lane(3, 1'b1, 1'b0, 32'd0, 32'd0);
        step("err_clear");
        chk_n("err_clear", freq_err, 4'b0000);

        // Wide-sum corner: both operands just below the modulus.
        set_lane(3, 1'b0, 1'b0, 32'd0, 32'd0);
        set_lane(0, 1'b1, 1'b0, 32'd99999999, 32'd0);
        step("max_load");
        set_lane(0, 1'b0, 1'b1, 32'd0, 32'hFFFF_FFFF);
        step("max_freq_reject");
        chk32("max_freq_acc0", acc[0 +: W], 32'd99999999);
        chk_n("max_freq_err", freq_err, 4'b0001);
        set_lane(0, 1'b1, 1'b0, 32'd99999999, 32'd0);
        step("max_reload");
        set_lane(0, 1'b0, 1'b1, 32'd0, 32'd99999999);
        step("max_sum");
        chk32("max_sum_acc0", acc[0 +: W], 32'd99999998);
        chk_n("max_sum_ovf", ovf, 4'b0001);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NCH; i++) begin
                set_lane(i, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
                         32'($urandom_range(0, 32'd199999999)),
                         ($urandom_range(0, 7) == 0) ? 32'($urandom())
                                                     : 32'($urandom_range(0, 32'd99999999)));
            end
            step("random");
        end

        // Asynchronous reset landing between clock edges.
        for (int i = 0; i < NCH; i++) begin
            set_lane(i, 1'b0, 1'b1, 32'd0, 32'(32'd30000000 + i));
        end
        step("pre_reset");
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        model_reset();
        @(posedge clk);
        #2;
        chk_all_zero("reset_held");
        reset = 1'b0;
        step("post_reset");
        chk32("post_reset_acc0", acc[0 +: W], 32'd30000000);

`ifdef NCO_OVF_CNT_EN
        push_s = '0;
        set_lane(0, 1'b1, 1'b0, 32'd0, 32'd0);
        step("cnt_clear");
        set_lane(0, 1'b0, 1'b1, 32'd0, 32'd99999999);
        for (int k = 1; k <= 65537; k++) begin
            step("cnt_run");
            if (k == 65536) begin
                total++;
                assert (ovf_cnt[15:0] === 16'd65535) else begin
                    bad++;
                    $error("FAIL cnt_max observed=%0d expected=65535", ovf_cnt[15:0]);
                end
            end
        end
        total++;
        assert (ovf_cnt[15:0] === 16'd0) else begin
            bad++;
            $error("FAIL cnt_wrap observed=%0d expected=0", ovf_cnt[15:0]);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
